// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] FETCH_INCR = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    RUN,
    HOLD
  } fetch_state_t;

  // Instruction addresses are word aligned; low bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with a synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  fetch_entry_t      data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output fetch_entry_t      data_o,
  output logic [CntW-1:0]   count_o
);

  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  fetch_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != Full);
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: credit-limited requests, in-order response buffering,
// and redirect handling that discards responses belonging to the old stream.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] mem_address_o,
  output logic        mem_read_enable_o,
  input  logic        mem_wait_req_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_read_data_i
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [31:0]     target_q, target_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic            pending_q;

  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   total;
  logic            fifo_valid;
  logic            credit_ok, accept, pend_now, drop_resp, push, pop;
  logic [31:0]     redir_pc;
  fetch_entry_t    push_entry, head_entry;

  // Credit counts stale requests too, so the FIFO can never overflow.
  assign total     = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign credit_ok = total < DepthW;

  assign mem_read_enable_o = !reset_i && (pending_q || credit_ok);
  assign mem_address_o     = fetch_pc_q;

  assign accept    = mem_read_enable_o && !mem_wait_req_i;
  assign pend_now  = mem_read_enable_o && mem_wait_req_i;
  assign drop_resp = (discard_q != '0);
  assign push      = mem_valid_i && !drop_resp && !redirect_i;
  assign pop       = fifo_valid && out_ready_i && !redirect_i;
  assign redir_pc  = align_pc(redirect_pc_i);

  assign push_entry = '{pc: resp_pc_q, inst: mem_read_data_i};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    target_d      = target_q;
    outstanding_d = outstanding_q + CntW'(accept) - CntW'(mem_valid_i);
    discard_d     = discard_q;

    if (mem_valid_i && drop_resp) discard_d = discard_q - 1'b1;
    if (push) resp_pc_d = resp_pc_q + FETCH_INCR;

    unique case (state_q)
      RUN: begin
        if (accept) fetch_pc_d = fetch_pc_q + FETCH_INCR;
      end
      HOLD: begin
        // The held request belongs to the old stream; its response must be dropped.
        if (accept) begin
          fetch_pc_d = target_q;
          discard_d  = discard_d + 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (redirect_i) begin
      resp_pc_d = redir_pc;
      discard_d = outstanding_d;
      if (pend_now) begin
        target_d = redir_pc;
        state_d  = HOLD;
      end else begin
        fetch_pc_d = redir_pc;
        state_d    = RUN;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      target_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      target_q      <= target_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pending_q     <= pend_now;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (head_entry),
    .count_o (fifo_count)
  );

  assign out_valid_o = fifo_valid;
  assign out_pc_o    = head_entry.pc;
  assign out_inst_o  = head_entry.inst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit with a stream-level reference model and memory model.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] mem_address;
  logic        mem_read_enable;
  logic        mem_wait_req;
  logic        mem_valid;
  logic [31:0] mem_read_data;

  always #5 clock = ~clock;

  inst_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock_i           (clock),
    .reset_i           (reset),
    .redirect_i        (redirect),
    .redirect_pc_i     (redirect_pc),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .out_inst_o        (out_inst),
    .out_pc_o          (out_pc),
    .mem_address_o     (mem_address),
    .mem_read_enable_o (mem_read_enable),
    .mem_wait_req_i    (mem_wait_req),
    .mem_valid_i       (mem_valid),
    .mem_read_data_i   (mem_read_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: next expected request address and next expected output pc.
  logic [31:0] exp_fetch, exp_pc, pend_addr;
  bit          hold_flag, pend_prev, after_redir;
  logic [31:0] mq_addr[$];
  int unsigned mq_due[$];
  int unsigned last_due, cyc;

  bit          wait_now, ready_now, redir_now;
  logic [31:0] redir_target;
  int unsigned lat_min, lat_max;

  bit          s_valid, s_en;
  logic [31:0] s_addr;
  int          accept_cnt, hs_cnt;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle; entered and left at the falling edge.
  task automatic step();
    bit          mv, acc, hs;
    int unsigned due;
    mv = (mq_addr.size() != 0) && (mq_due[0] <= cyc);
    mem_valid     = mv;
    mem_read_data = mv ? mem_fn(mq_addr[0]) : $urandom;
    mem_wait_req  = wait_now;
    redirect      = redir_now;
    redirect_pc   = redir_target;
    out_ready     = ready_now;
    #1;
    s_valid = out_valid;
    s_en    = mem_read_enable;
    s_addr  = mem_address;
    if (after_redir) check_eq("flush_valid", {31'b0, out_valid}, 32'd0);
    if (pend_prev) begin
      check_eq("pend_en", {31'b0, mem_read_enable}, 32'd1);
      check_eq("pend_addr", mem_address, pend_addr);
    end
    hs = out_valid && out_ready && !redirect;
    if (hs) begin
      check_eq("out_pc", out_pc, exp_pc);
      check_eq("out_inst", out_inst, mem_fn(exp_pc));
      exp_pc += 32'd4;
      hs_cnt++;
    end
    acc = mem_read_enable && !mem_wait_req;
    if (acc) begin
      if (hold_flag) hold_flag = 1'b0;
      else begin
        check_eq("req_addr", mem_address, exp_fetch);
        exp_fetch += 32'd4;
      end
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due < last_due) due = last_due;
      last_due = due;
      mq_addr.push_back(mem_address);
      mq_due.push_back(due);
      accept_cnt++;
    end
    if (mv) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    check_eq("inflight_cap", {31'b0, mq_addr.size() <= DEPTH}, 32'd1);
    if (redirect) begin
      if (mem_read_enable && mem_wait_req) begin
        if (!hold_flag) check_eq("req_addr_held", mem_address, exp_fetch);
        hold_flag = 1'b1;
      end
      exp_fetch = redirect_pc & ~32'h3;
      exp_pc    = redirect_pc & ~32'h3;
    end
    after_redir = redirect;
    pend_prev   = mem_read_enable && mem_wait_req;
    pend_addr   = mem_address;
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    int snap_acc, snap_hs;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    mem_wait_req = 1'b0; mem_valid = 1'b0; mem_read_data = '0;
    wait_now = 0; ready_now = 1; redir_now = 0; redir_target = '0;
    lat_min = 1; lat_max = 1; last_due = 0; cyc = 0;
    hold_flag = 0; pend_prev = 0; after_redir = 0;
    exp_fetch = RESET_PC; exp_pc = RESET_PC;
    accept_cnt = 0; hs_cnt = 0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_read_en", {31'b0, mem_read_enable}, 32'd0);
    check_eq("rst_address", mem_address, RESET_PC);
    reset = 1'b0;

    // Zero-wait, latency-1 streaming: one instruction per cycle from cycle 2.
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) begin
        check_eq("first_req_en", {31'b0, s_en}, 32'd1);
        check_eq("first_req_addr", s_addr, RESET_PC);
      end
      check_eq("stream_valid", {31'b0, s_valid}, {31'b0, i >= 2});
    end

    // Backpressure fills exactly DEPTH credits, then a single pop frees one request.
    ready_now = 0;
    repeat (10) step();
    check_eq("bp_read_en", {31'b0, s_en}, 32'd0);
    check_eq("bp_valid", {31'b0, s_valid}, 32'd1);
    snap_acc = accept_cnt; snap_hs = hs_cnt;
    ready_now = 1; step();
    ready_now = 0; repeat (6) step();
    check_eq("bp_one_req", accept_cnt - snap_acc, 32'd1);
    check_eq("bp_one_pop", hs_cnt - snap_hs, 32'd1);

    // Unaligned redirect near the top of the address space wraps to zero.
    ready_now = 1; redir_now = 1; redir_target = 32'hFFFF_FFFE;
    step();
    redir_now = 0;
    step();
    check_eq("wrap_req_en", {31'b0, s_en}, 32'd1);
    check_eq("wrap_req_addr", s_addr, 32'hFFFF_FFFC);
    snap_hs = hs_cnt;
    repeat (8) step();
    check_eq("wrap_progress", {31'b0, (hs_cnt - snap_hs) >= 4}, 32'd1);
    check_eq("wrap_exp_pc", {31'b0, exp_pc >= 32'h0000_0008 && exp_pc < 32'h0000_0100}, 32'd1);

    // Redirect while the memory stalls a request for three cycles.
    wait_now = 1; redir_now = 1; redir_target = 32'h0000_2000;
    step();
    check_eq("wr_pending", {31'b0, s_en}, 32'd1);
    redir_now = 0;
    repeat (2) step();
    wait_now = 0;
    repeat (12) step();
    check_eq("wr_progress", {31'b0, exp_pc >= 32'h0000_2008 && exp_pc < 32'h0000_2100}, 32'd1);

    // Random traffic: stalls, variable latency, backpressure and redirects.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      wait_now  = ($urandom_range(99) < 25);
      ready_now = ($urandom_range(99) < 70);
      redir_now = ($urandom_range(99) < 3);
      redir_target = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step();
    end
    redir_now = 0; wait_now = 0; ready_now = 1;
    repeat (20) step();
    check_eq("final_progress", {31'b0, hs_cnt > 500}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
